// File: rtl/l2_bank_arb_pkg.sv
// Shared types for the L2 bank arbiter: the bank-level FSM states.
package l2_bank_arb_pkg;

    typedef enum logic {
        INIT,
        SERVE
    } state_e;

endpackage

// File: rtl/l2_rr_arbiter.sv
// Round-robin arbiter: the first requester at or after the rotating pointer wins,
// and the pointer moves one past the winner on every grant.
module l2_rr_arbiter #(
    parameter int NB_REQ = 2,
    parameter int IDX_W  = $clog2(NB_REQ)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NB_REQ-1:0] req_i,
    input  logic              en_i,
    output logic [NB_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]  idx_o
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] cand;
    logic             found;

    // NOTE: every variable gets a default at the top so no path through the block leaves one unassigned (no latch).
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < NB_REQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NB_REQ);
            if (en_i && !found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

    // NOTE: registers use non-blocking assignments so each flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (idx_o == IDX_W'(NB_REQ - 1)) ? '0 : idx_o + 1'b1;
        end
    end

endmodule

// File: rtl/l2_bank_arbiter.sv
// Shares one single-port L2 SRAM bank among NB_REQ requesters (round-robin) and
// sweeps the bank to zero after reset or on request.
module l2_bank_arbiter
    import l2_bank_arb_pkg::*;
#(
    parameter int NB_REQ        = 2,
    parameter int ADDR_WIDTH    = 13,
    parameter int DATA_WIDTH    = 32,
    parameter int INIT_ON_RESET = 1,
    localparam int BE_WIDTH     = DATA_WIDTH / 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           init_req_i,
    output logic                           init_done_o,
    input  logic [NB_REQ-1:0]              req_i,
    input  logic [NB_REQ-1:0]              we_i,
    input  logic [NB_REQ*ADDR_WIDTH-1:0]   addr_i,
    input  logic [NB_REQ*BE_WIDTH-1:0]     be_i,
    input  logic [NB_REQ*DATA_WIDTH-1:0]   wdata_i,
    output logic [NB_REQ-1:0]              gnt_o,
    output logic [NB_REQ-1:0]              rvalid_o,
    output logic [DATA_WIDTH-1:0]          rdata_o,
    output logic                           mem_csn_o,
    output logic                           mem_wen_o,
    output logic [BE_WIDTH-1:0]            mem_be_o,
    output logic [ADDR_WIDTH-1:0]          mem_add_o,
    output logic [DATA_WIDTH-1:0]          mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]          mem_rdata_i
);

    localparam int IDX_W = $clog2(NB_REQ);

    state_e                state;
    state_e                state_next;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [NB_REQ-1:0]     gnt;
    logic [IDX_W-1:0]      win;
    logic                  arb_en;

    // The bus is held idle during the reset cycle, whatever state the FSM was in.
    assign arb_en = (state == SERVE) && !rst_i;

    l2_rr_arbiter #(
        .NB_REQ (NB_REQ)
    ) u_rr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i (req_i),
        .en_i  (arb_en),
        .gnt_o (gnt),
        .idx_o (win)
    );

    assign gnt_o       = gnt;
    assign init_done_o = (state == SERVE);
    assign rdata_o     = mem_rdata_i;

    // The sweep counter wraps to zero on its last write and is held at zero while serving.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= (INIT_ON_RESET != 0) ? INIT : SERVE;
            cnt      <= '0;
            rvalid_o <= '0;
        end else begin
            state    <= state_next;
            cnt      <= (state == INIT) ? cnt + 1'b1 : '0;
            rvalid_o <= gnt;
        end
    end

    always_comb begin
        state_next  = state;
        mem_csn_o   = 1'b1;
        mem_wen_o   = 1'b1;
        mem_be_o    = '0;
        mem_add_o   = '0;
        mem_wdata_o = '0;
        case (state)
            INIT: begin
                if (cnt == '1) begin
                    state_next = SERVE;
                end
                if (!rst_i) begin
                    mem_csn_o = 1'b0;
                    mem_wen_o = 1'b0;
                    mem_be_o  = '1;
                    mem_add_o = cnt;
                end
            end
            SERVE: begin
                if (init_req_i) begin
                    state_next = INIT;
                end
                if (|gnt) begin
                    mem_csn_o   = 1'b0;
                    mem_wen_o   = !we_i[win];
                    mem_be_o    = be_i[int'(win)*BE_WIDTH +: BE_WIDTH];
                    mem_add_o   = addr_i[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
                    mem_wdata_o = wdata_i[int'(win)*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            default: state_next = state;
        endcase
    end

endmodule

// File: tb/tb_l2_bank_arbiter.sv
// Bench for l2_bank_arbiter: a 2-requester instance for directed scenarios and a
// 3-requester instance for random traffic, each backed by a 1-cycle-latency SRAM model.
module tb_l2_bank_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        bit          rd;
        logic [31:0] data;
    } rsp_t;

    // ---------------- 2-requester instance ----------------
    logic        rst2 = 1'b1, init_req2 = 1'b0;
    logic [1:0]  req2 = '0, we2 = '0;
    logic [7:0]  addr2 = '0, be2 = '0;
    logic [63:0] wdata2 = '0;
    logic        init_done2, csn2, wen2;
    logic [1:0]  gnt2, rvalid2;
    logic [31:0] rdata2, mwdata2, mrdata2;
    logic [3:0]  mbe2, madd2;
    logic [31:0] sram2 [16];

    l2_bank_arbiter #(.NB_REQ(2), .ADDR_WIDTH(4), .DATA_WIDTH(32), .INIT_ON_RESET(1)) u_dut2 (
        .clk_i(clk), .rst_i(rst2), .init_req_i(init_req2), .init_done_o(init_done2),
        .req_i(req2), .we_i(we2), .addr_i(addr2), .be_i(be2), .wdata_i(wdata2),
        .gnt_o(gnt2), .rvalid_o(rvalid2), .rdata_o(rdata2),
        .mem_csn_o(csn2), .mem_wen_o(wen2), .mem_be_o(mbe2), .mem_add_o(madd2),
        .mem_wdata_o(mwdata2), .mem_rdata_i(mrdata2)
    );

    always @(posedge clk) begin
        if (!csn2) begin
            if (!wen2) begin
                for (int b = 0; b < 4; b++)
                    if (mbe2[b]) sram2[madd2][8*b +: 8] <= mwdata2[8*b +: 8];
            end else begin
                mrdata2 <= sram2[madd2];
            end
        end
    end

    // ---------------- 3-requester instance ----------------
    logic        rst3 = 1'b1, init_req3 = 1'b0;
    logic [2:0]  req3 = '0, we3 = '0;
    logic [11:0] addr3 = '0, be3 = '0;
    logic [95:0] wdata3 = '0;
    logic        init_done3, csn3, wen3;
    logic [2:0]  gnt3, rvalid3;
    logic [31:0] rdata3, mwdata3, mrdata3;
    logic [3:0]  mbe3, madd3;
    logic [31:0] sram3 [16];

    l2_bank_arbiter #(.NB_REQ(3), .ADDR_WIDTH(4), .DATA_WIDTH(32), .INIT_ON_RESET(1)) u_dut3 (
        .clk_i(clk), .rst_i(rst3), .init_req_i(init_req3), .init_done_o(init_done3),
        .req_i(req3), .we_i(we3), .addr_i(addr3), .be_i(be3), .wdata_i(wdata3),
        .gnt_o(gnt3), .rvalid_o(rvalid3), .rdata_o(rdata3),
        .mem_csn_o(csn3), .mem_wen_o(wen3), .mem_be_o(mbe3), .mem_add_o(madd3),
        .mem_wdata_o(mwdata3), .mem_rdata_i(mrdata3)
    );

    always @(posedge clk) begin
        if (!csn3) begin
            if (!wen3) begin
                for (int b = 0; b < 4; b++)
                    if (mbe3[b]) sram3[madd3][8*b +: 8] <= mwdata3[8*b +: 8];
            end else begin
                mrdata3 <= sram3[madd3];
            end
        end
    end

    // ---------------- reference model state for the 2-requester instance ----------------
    bit          m_init2 = 1'b1;
    int          m_cnt2  = 0;
    int          m_ptr2  = 0;
    logic [1:0]  m_rv2   = '0;
    logic [31:0] gold2 [16];
    rsp_t        q2 [$];

    logic [1:0]  o_gnt, o_rv;
    logic        o_csn, o_wen, o_done;
    logic [3:0]  o_add;
    logic [31:0] o_rdata;

    // One clock of the 2-requester instance: inputs were set after the previous posedge;
    // outputs are sampled on the negedge, checked against the model, then the model advances.
    task automatic step2();
        int         win;
        logic [1:0] eg;
        logic       exp_csn;
        logic [3:0] a;
        rsp_t       r;
        @(negedge clk);
        win = -1;
        if (!rst2 && !m_init2)
            for (int k = 0; k < 2; k++)
                if (win < 0 && req2[(m_ptr2 + k) % 2]) win = (m_ptr2 + k) % 2;
        eg      = (win >= 0) ? 2'(1 << win) : 2'b00;
        exp_csn = rst2 ? 1'b1 : (m_init2 ? 1'b0 : (win < 0));

        n_checks++;
        if (gnt2 !== eg) $display("FAIL mon_gnt: got %b expected %b at %0t", gnt2, eg, $time);
        else n_pass++;
        n_checks++;
        if (csn2 !== exp_csn) $display("FAIL mon_csn: got %b expected %b at %0t", csn2, exp_csn, $time);
        else n_pass++;
        n_checks++;
        if (init_done2 !== !m_init2) $display("FAIL mon_init_done: got %b expected %b at %0t", init_done2, !m_init2, $time);
        else n_pass++;

        if (!rst2 && m_init2) begin
            n_checks++;
            if ({wen2, mbe2, madd2, mwdata2} !== {1'b0, 4'hf, 4'(m_cnt2), 32'h0})
                $display("FAIL mon_sweep: got wen=%b be=%h add=%0d wdata=%h expected add=%0d at %0t",
                         wen2, mbe2, madd2, mwdata2, m_cnt2, $time);
            else n_pass++;
        end else if (win >= 0) begin
            a = addr2[win*4 +: 4];
            n_checks++;
            if ({wen2, madd2} !== {!we2[win], a})
                $display("FAIL mon_access: got wen=%b add=%0d expected wen=%b add=%0d at %0t", wen2, madd2, !we2[win], a, $time);
            else n_pass++;
            if (we2[win]) begin
                n_checks++;
                if ({mbe2, mwdata2} !== {be2[win*4 +: 4], wdata2[win*32 +: 32]})
                    $display("FAIL mon_wfields: got be=%h wdata=%h expected be=%h wdata=%h at %0t",
                             mbe2, mwdata2, be2[win*4 +: 4], wdata2[win*32 +: 32], $time);
                else n_pass++;
            end
        end

        n_checks++;
        if (rvalid2 !== m_rv2) $display("FAIL mon_rvalid: got %b expected %b at %0t", rvalid2, m_rv2, $time);
        else n_pass++;
        if (m_rv2 != 2'b00) begin
            if (q2.size() == 0) begin
                n_checks++;
                $display("FAIL mon_queue: got empty scoreboard expected one entry at %0t", $time);
            end else begin
                r = q2.pop_front();
                if (r.rd) begin
                    n_checks++;
                    if (rdata2 !== r.data) $display("FAIL mon_rdata: got %h expected %h at %0t", rdata2, r.data, $time);
                    else n_pass++;
                end
            end
        end

        o_gnt = gnt2; o_rv = rvalid2; o_csn = csn2; o_wen = wen2;
        o_done = init_done2; o_add = madd2; o_rdata = rdata2;

        if (rst2) begin
            m_init2 = 1'b1; m_cnt2 = 0; m_ptr2 = 0; m_rv2 = '0;
            q2.delete();
        end else if (m_init2) begin
            gold2[m_cnt2] = '0;
            if (m_cnt2 == 15) m_init2 = 1'b0;
            m_cnt2 = (m_cnt2 + 1) % 16;
            m_rv2  = '0;
        end else begin
            if (win >= 0) begin
                a      = addr2[win*4 +: 4];
                r.rd   = !we2[win];
                r.data = gold2[a];
                if (we2[win])
                    for (int b = 0; b < 4; b++)
                        if (be2[win*4 + b]) gold2[a][8*b +: 8] = wdata2[win*32 + 8*b +: 8];
                q2.push_back(r);
                m_ptr2 = (win + 1) % 2;
            end
            m_rv2 = eg;
            if (init_req2) begin
                m_init2 = 1'b1;
                m_cnt2  = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst2 = 1'b1; req2 = '0; init_req2 = 1'b0;
        step2();
        step2();
        n_checks++;
        if ({o_gnt, o_rv} !== 4'b0000) $display("FAIL reset_gnt_rvalid: got gnt=%b rvalid=%b expected 00/00", o_gnt, o_rv);
        else n_pass++;
        n_checks++;
        if ({o_csn, o_wen, o_done} !== 3'b110) $display("FAIL reset_bus: got csn=%b wen=%b done=%b expected 1/1/0", o_csn, o_wen, o_done);
        else n_pass++;
        rst2 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step2();
            n_checks++;
            if ({o_csn, o_wen, o_gnt, o_add, o_done} !== {1'b0, 1'b0, 2'b00, 4'(i), 1'b0})
                $display("FAIL reset_sweep: got csn=%b wen=%b gnt=%b add=%0d done=%b expected write of addr %0d",
                         o_csn, o_wen, o_gnt, o_add, o_done, i);
            else n_pass++;
        end
        step2();
        n_checks++;
        if (o_done !== 1'b1) $display("FAIL reset_done_cycle16: got %b expected 1", o_done);
        else n_pass++;
    endtask

    task automatic test_rr_alternation();
        logic [1:0] seq [4];
        logic [1:0] prev;
        seq  = '{2'b01, 2'b10, 2'b01, 2'b10};
        prev = 2'b00;
        req2 = 2'b11; we2 = 2'b00; addr2 = {4'd1, 4'd0};
        for (int i = 0; i < 4; i++) begin
            step2();
            n_checks++;
            if (o_gnt !== seq[i]) $display("FAIL rr_gnt[%0d]: got %b expected %b", i, o_gnt, seq[i]);
            else n_pass++;
            n_checks++;
            if (o_rv !== prev) $display("FAIL rr_rvalid[%0d]: got %b expected %b", i, o_rv, prev);
            else n_pass++;
            prev = seq[i];
        end
        req2 = 2'b00;
        step2();
        n_checks++;
        if ({o_gnt, o_rv} !== {2'b00, prev}) $display("FAIL rr_drain: got gnt=%b rvalid=%b expected 00/%b", o_gnt, o_rv, prev);
        else n_pass++;
    endtask

    task automatic test_byte_write_read();
        req2 = 2'b01; we2 = 2'b01; addr2 = {4'd0, 4'd5}; be2 = {4'b0000, 4'b0011};
        wdata2 = {32'h0, 32'hDEAD_BEEF};
        step2();
        n_checks++;
        if (o_gnt !== 2'b01) $display("FAIL bw_write_gnt: got %b expected 01", o_gnt);
        else n_pass++;
        req2 = 2'b10; we2 = 2'b00; addr2 = {4'd5, 4'd5};
        step2();
        n_checks++;
        if ({o_gnt, o_rv} !== 4'b1001) $display("FAIL bw_read_gnt: got gnt=%b rvalid=%b expected 10/01", o_gnt, o_rv);
        else n_pass++;
        req2 = 2'b00;
        step2();
        n_checks++;
        if (o_rv !== 2'b10 || o_rdata !== 32'h0000_BEEF)
            $display("FAIL bw_rdata: got rvalid=%b rdata=%h expected 10/0000beef", o_rv, o_rdata);
        else n_pass++;
    endtask

    task automatic test_init_request();
        req2 = 2'b01; we2 = 2'b00; addr2 = {4'd0, 4'd5};
        step2();
        init_req2 = 1'b1;
        step2();
        init_req2 = 1'b0;
        n_checks++;
        if (o_gnt !== 2'b01) $display("FAIL init_req_same_cycle_gnt: got %b expected 01", o_gnt);
        else n_pass++;
        for (int i = 0; i < 16; i++) begin
            step2();
            n_checks++;
            if ({o_gnt, o_csn, o_add, o_done} !== {2'b00, 1'b0, 4'(i), 1'b0})
                $display("FAIL init_req_sweep[%0d]: got gnt=%b csn=%b add=%0d done=%b", i, o_gnt, o_csn, o_add, o_done);
            else n_pass++;
            n_checks++;
            if (o_rv !== ((i == 0) ? 2'b01 : 2'b00)) $display("FAIL init_req_rvalid[%0d]: got %b", i, o_rv);
            else n_pass++;
        end
        step2();
        n_checks++;
        if ({o_done, o_gnt} !== 3'b101) $display("FAIL init_req_resume: got done=%b gnt=%b expected 1/01", o_done, o_gnt);
        else n_pass++;
        req2 = 2'b00;
        step2();
        n_checks++;
        if (o_rv !== 2'b01 || o_rdata !== 32'h0) $display("FAIL init_req_zeroed: got rvalid=%b rdata=%h expected 01/0", o_rv, o_rdata);
        else n_pass++;
    endtask

    task automatic test_reset_mid_sweep();
        init_req2 = 1'b1;
        step2();
        init_req2 = 1'b0;
        for (int i = 0; i < 7; i++) step2();
        rst2 = 1'b1;
        step2();
        n_checks++;
        if ({o_csn, o_rv} !== 3'b100) $display("FAIL midrst_cycle: got csn=%b rvalid=%b expected 1/00", o_csn, o_rv);
        else n_pass++;
        rst2 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step2();
            n_checks++;
            if ({o_add, o_rv} !== {4'(i), 2'b00}) $display("FAIL midrst_restart[%0d]: got add=%0d rvalid=%b", i, o_add, o_rv);
            else n_pass++;
        end
        step2();
        n_checks++;
        if (o_done !== 1'b1) $display("FAIL midrst_done: got %b expected 1", o_done);
        else n_pass++;
    endtask

    task automatic test_random_3req();
        logic [31:0] gold3 [16];
        rsp_t        q3 [$];
        rsp_t        r;
        int          ptr3, win, waitc [3];
        logic [2:0]  pend, exp_g, exp_rv3;
        logic [3:0]  a;

        rst3 = 1'b0;
        repeat (16) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (init_done3 !== 1'b1) $display("FAIL rand_init_done: got %b expected 1", init_done3);
        else n_pass++;
        for (int i = 0; i < 16; i++) gold3[i] = '0;
        ptr3 = 0; pend = '0; exp_rv3 = '0;
        for (int i = 0; i < 3; i++) waitc[i] = 0;

        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        pend[i]             = 1'b1;
                        we3[i]              = 1'($urandom_range(0, 1));
                        addr3[i*4 +: 4]     = 4'($urandom_range(0, 15));
                        be3[i*4 +: 4]       = 4'($urandom_range(0, 15));
                        wdata3[i*32 +: 32]  = $urandom();
                    end
                end else if ($urandom_range(0, 31) == 0) begin
                    pend[i]  = 1'b0;
                    waitc[i] = 0;
                end
            end
            req3 = pend;
            @(negedge clk);

            win = -1;
            for (int k = 0; k < 3; k++)
                if (win < 0 && pend[(ptr3 + k) % 3]) win = (ptr3 + k) % 3;
            exp_g = (win >= 0) ? 3'(1 << win) : 3'b000;

            n_checks++;
            if (gnt3 !== exp_g) $display("FAIL rand_gnt: got %b expected %b at cycle %0d", gnt3, exp_g, cyc);
            else n_pass++;
            n_checks++;
            if (rvalid3 !== exp_rv3) $display("FAIL rand_rvalid: got %b expected %b at cycle %0d", rvalid3, exp_rv3, cyc);
            else n_pass++;
            if (exp_rv3 != 3'b000 && q3.size() > 0) begin
                r = q3.pop_front();
                if (r.rd) begin
                    n_checks++;
                    if (rdata3 !== r.data) $display("FAIL rand_rdata: got %h expected %h at cycle %0d", rdata3, r.data, cyc);
                    else n_pass++;
                end
            end

            if (win >= 0) begin
                a = addr3[win*4 +: 4];
                n_checks++;
                if ({csn3, wen3, madd3} !== {1'b0, !we3[win], a})
                    $display("FAIL rand_access: got csn=%b wen=%b add=%0d expected wen=%b add=%0d", csn3, wen3, madd3, !we3[win], a);
                else n_pass++;
                n_checks++;
                if (waitc[win] > 2) $display("FAIL rand_starvation: got wait %0d expected <= 2 for requester %0d", waitc[win], win);
                else n_pass++;
                r.rd   = !we3[win];
                r.data = gold3[a];
                if (we3[win])
                    for (int b = 0; b < 4; b++)
                        if (be3[win*4 + b]) gold3[a][8*b +: 8] = wdata3[win*32 + 8*b +: 8];
                q3.push_back(r);
                ptr3       = (win + 1) % 3;
                pend[win]  = 1'b0;
                waitc[win] = 0;
            end
            for (int i = 0; i < 3; i++)
                if (pend[i]) waitc[i]++;
            exp_rv3 = exp_g;
        end

        @(posedge clk);
        #1;
        req3 = '0;
        @(negedge clk);
        n_checks++;
        if (rvalid3 !== exp_rv3) $display("FAIL rand_last_rvalid: got %b expected %b", rvalid3, exp_rv3);
        else n_pass++;
        if (exp_rv3 != 3'b000 && q3.size() > 0) begin
            r = q3.pop_front();
            if (r.rd) begin
                n_checks++;
                if (rdata3 !== r.data) $display("FAIL rand_last_rdata: got %h expected %h", rdata3, r.data);
                else n_pass++;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_rr_alternation();
        test_byte_write_read();
        test_init_request();
        test_reset_mid_sweep();
        test_random_3req();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
